// File: rtl/wb_pkg.sv
// Shared constants and entry type for the write-back buffer.
// Defaults for queue depth, data width and register select width.
package wb_pkg;

   localparam int WB_DEPTH      = 4;
   localparam int WB_DATA_WIDTH = 32;
   localparam int WB_ADDR_WIDTH = 5;

   typedef struct packed {
      logic [WB_ADDR_WIDTH-1:0] sel;
      logic [WB_DATA_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/wb_lookup.sv
// Youngest-match search over the queued entries for one decode read port.
// Ports: entry arrays, head, count, lookup select in; hit and hit data out.
module wb_lookup
   import wb_pkg::*;
#(
   parameter int DEPTH      = WB_DEPTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
   parameter int PTR_W      = $clog2(DEPTH),
   parameter int CNT_W      = PTR_W + 1
) (
   input  logic [DEPTH-1:0][ADDR_WIDTH-1:0] sel_arr,
   input  logic [DEPTH-1:0][DATA_WIDTH-1:0] data_arr,
   input  logic [PTR_W-1:0]                 head,
   input  logic [CNT_W-1:0]                 count,
   input  logic [ADDR_WIDTH-1:0]            lookup_sel,
   output logic                             hit,
   output logic [DATA_WIDTH-1:0]            hit_data
);

   logic [PTR_W-1:0] idx;

   // Walk oldest to youngest so the last match seen is the youngest.
   always_comb begin
      hit      = 1'b0;
      hit_data = '0;
      idx      = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head + PTR_W'(i);
         if ((CNT_W'(i) < count) && (lookup_sel != '0) &&
             (sel_arr[idx] == lookup_sel)) begin
            hit      = 1'b1;
            hit_data = data_arr[idx];
         end
      end
   end

endmodule

// File: rtl/write_back_buffer.sv
// Queues completed results and drains one per cycle into the register file.
// Ports: In* handshake, Write* drain, Lookup*/Hit* forwarding, PendingMask, Count.
module write_back_buffer
   import wb_pkg::*;
#(
   parameter int DEPTH      = WB_DEPTH,
   parameter int DATA_WIDTH = WB_DATA_WIDTH,
   parameter int ADDR_WIDTH = WB_ADDR_WIDTH
) (
   input  logic                         Clk,
   input  logic                         Reset,
   input  logic                         InValid,
   output logic                         InReady,
   input  logic [ADDR_WIDTH-1:0]        InSelect,
   input  logic [DATA_WIDTH-1:0]        InData,
   input  logic                         PortBusy,
   output logic                         WriteEnable,
   output logic [ADDR_WIDTH-1:0]        WriteSelect,
   output logic [DATA_WIDTH-1:0]        WriteData,
   input  logic [ADDR_WIDTH-1:0]        LookupSelect1,
   input  logic [ADDR_WIDTH-1:0]        LookupSelect2,
   output logic                         Hit1,
   output logic                         Hit2,
   output logic [DATA_WIDTH-1:0]        HitData1,
   output logic [DATA_WIDTH-1:0]        HitData2,
   output logic [(1<<ADDR_WIDTH)-1:0]   PendingMask,
   output logic [$clog2(DEPTH):0]       Count
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NREG  = 1 << ADDR_WIDTH;

   logic [DEPTH-1:0][ADDR_WIDTH-1:0] sel_q, sel_d;
   logic [DEPTH-1:0][DATA_WIDTH-1:0] data_q, data_d;
   logic [PTR_W-1:0]                 head_q, head_d;
   logic [PTR_W-1:0]                 tail_q, tail_d;
   logic [CNT_W-1:0]                 count_q, count_d;

   logic             in_ready;
   logic             not_empty;
   logic             push;
   logic             pop;
   logic [PTR_W-1:0] idx;
   logic [NREG-1:0]  mask;

   // No pass-through when full, even if the head drains this cycle.
   assign in_ready  = (count_q != CNT_W'(DEPTH));
   assign not_empty = (count_q != '0);
   // Select 0 completes the handshake but is never stored.
   assign push      = InValid & in_ready & (InSelect != '0);
   assign pop       = not_empty & ~PortBusy;

   always_comb begin
      sel_d   = sel_q;
      data_d  = data_q;
      head_d  = head_q;
      tail_d  = tail_q;
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (push) begin
         sel_d[tail_q]  = InSelect;
         data_d[tail_q] = InData;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (pop) begin
         head_d = head_q + PTR_W'(1);
      end
   end

   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         sel_q   <= '0;
         data_q  <= '0;
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         sel_q   <= sel_d;
         data_q  <= data_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   always_comb begin
      mask = '0;
      idx  = '0;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head_q + PTR_W'(i);
         if (CNT_W'(i) < count_q) begin
            mask[sel_q[idx]] = 1'b1;
         end
      end
      mask[0] = 1'b0;
   end

   assign InReady     = in_ready;
   assign WriteEnable = pop;
   assign WriteSelect = not_empty ? sel_q[head_q] : '0;
   assign WriteData   = not_empty ? data_q[head_q] : '0;
   assign PendingMask = mask;
   assign Count       = count_q;

   wb_lookup #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_lookup1 (
      .sel_arr    (sel_q),
      .data_arr   (data_q),
      .head       (head_q),
      .count      (count_q),
      .lookup_sel (LookupSelect1),
      .hit        (Hit1),
      .hit_data   (HitData1)
   );

   wb_lookup #(
      .DEPTH      (DEPTH),
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_lookup2 (
      .sel_arr    (sel_q),
      .data_arr   (data_q),
      .head       (head_q),
      .count      (count_q),
      .lookup_sel (LookupSelect2),
      .hit        (Hit2),
      .hit_data   (HitData2)
   );

endmodule

// File: tb/tb_write_back_buffer.sv
// Directed bench for write_back_buffer with default parameters.
// Each task drives one scenario and checks outputs against hand values.
module tb_write_back_buffer;
   import wb_pkg::*;

   logic        Clk;
   logic        Reset;
   logic        InValid;
   logic        InReady;
   logic [4:0]  InSelect;
   logic [31:0] InData;
   logic        PortBusy;
   logic        WriteEnable;
   logic [4:0]  WriteSelect;
   logic [31:0] WriteData;
   logic [4:0]  LookupSelect1;
   logic [4:0]  LookupSelect2;
   logic        Hit1;
   logic        Hit2;
   logic [31:0] HitData1;
   logic [31:0] HitData2;
   logic [31:0] PendingMask;
   logic [2:0]  Count;

   int total = 0;
   int bad   = 0;

   write_back_buffer dut (
      .Clk           (Clk),
      .Reset         (Reset),
      .InValid       (InValid),
      .InReady       (InReady),
      .InSelect      (InSelect),
      .InData        (InData),
      .PortBusy      (PortBusy),
      .WriteEnable   (WriteEnable),
      .WriteSelect   (WriteSelect),
      .WriteData     (WriteData),
      .LookupSelect1 (LookupSelect1),
      .LookupSelect2 (LookupSelect2),
      .Hit1          (Hit1),
      .Hit2          (Hit2),
      .HitData1      (HitData1),
      .HitData2      (HitData2),
      .PendingMask   (PendingMask),
      .Count         (Count)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic test_reset();
      PortBusy = 1'b1;
      InValid  = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         InSelect = 5'(i);
         InData   = 32'h50 + 32'(i);
         step();
      end
      InValid = 1'b0;
      LookupSelect1 = 5'd2;
      #1;
      total++;
      if (Count !== 3'd3) begin
         bad++;
         $display("FAIL rst_pre_count got=%0d exp=3", Count);
      end
      #1 Reset = 1'b0;
      #1;
      total++;
      if (Count !== 3'd0 || WriteEnable !== 1'b0 ||
          WriteSelect !== 5'd0 || WriteData !== 32'd0) begin
         bad++;
         $display("FAIL rst_async got cnt=%0d we=%b ws=%0d wd=%h exp 0",
                  Count, WriteEnable, WriteSelect, WriteData);
      end
      total++;
      if (Hit1 !== 1'b0 || HitData1 !== 32'd0 || PendingMask !== 32'd0) begin
         bad++;
         $display("FAIL rst_async_lookup got hit=%b hd=%h pm=%h exp 0",
                  Hit1, HitData1, PendingMask);
      end
      @(negedge Clk);
      Reset = 1'b1;
      step();
      total++;
      if (InReady !== 1'b1 || Count !== 3'd0) begin
         bad++;
         $display("FAIL rst_release got rdy=%b cnt=%0d exp rdy=1 cnt=0",
                  InReady, Count);
      end
   endtask

   task automatic test_single();
      PortBusy      = 1'b0;
      InValid       = 1'b1;
      InSelect      = 5'd5;
      InData        = 32'hDEADBEEF;
      LookupSelect1 = 5'd5;
      #1;
      total++;
      if (Hit1 !== 1'b0) begin
         bad++;
         $display("FAIL single_offer_hit got=%b exp=0", Hit1);
      end
      step();
      InValid = 1'b0;
      #1;
      total++;
      if (WriteEnable !== 1'b1 || WriteSelect !== 5'd5 ||
          WriteData !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL single_drain got we=%b ws=%0d wd=%h exp 1 5 deadbeef",
                  WriteEnable, WriteSelect, WriteData);
      end
      total++;
      if (Hit1 !== 1'b1 || HitData1 !== 32'hDEADBEEF ||
          PendingMask !== 32'h20) begin
         bad++;
         $display("FAIL single_hit got hit=%b hd=%h pm=%h exp 1 deadbeef 20",
                  Hit1, HitData1, PendingMask);
      end
      step();
      total++;
      if (Hit1 !== 1'b0 || PendingMask !== 32'd0 ||
          WriteEnable !== 1'b0 || Count !== 3'd0) begin
         bad++;
         $display("FAIL single_after got hit=%b pm=%h we=%b cnt=%0d exp 0",
                  Hit1, PendingMask, WriteEnable, Count);
      end
   endtask

   task automatic test_full();
      PortBusy = 1'b1;
      InValid  = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         InSelect = 5'(i);
         InData   = 32'h100 + 32'(i);
         step();
      end
      InSelect = 5'd9;
      InData   = 32'h109;
      LookupSelect2 = 5'd9;
      #1;
      total++;
      if (Count !== 3'd4 || InReady !== 1'b0) begin
         bad++;
         $display("FAIL full_count got cnt=%0d rdy=%b exp 4 0", Count, InReady);
      end
      step();
      total++;
      if (Count !== 3'd4 || Hit2 !== 1'b0) begin
         bad++;
         $display("FAIL full_hold got cnt=%0d hit2=%b exp 4 0", Count, Hit2);
      end
      PortBusy = 1'b0;
      #1;
      total++;
      if (WriteEnable !== 1'b1 || WriteSelect !== 5'd1 ||
          WriteData !== 32'h101) begin
         bad++;
         $display("FAIL full_drain1 got we=%b ws=%0d wd=%h exp 1 1 101",
                  WriteEnable, WriteSelect, WriteData);
      end
      step();
      total++;
      if (Count !== 3'd3 || InReady !== 1'b1 || WriteSelect !== 5'd2) begin
         bad++;
         $display("FAIL full_drain2 got cnt=%0d rdy=%b ws=%0d exp 3 1 2",
                  Count, InReady, WriteSelect);
      end
      step();
      InValid = 1'b0;
      #1;
      total++;
      if (Count !== 3'd3 || WriteSelect !== 5'd3 ||
          Hit2 !== 1'b1 || HitData2 !== 32'h109) begin
         bad++;
         $display("FAIL full_fifth got cnt=%0d ws=%0d hit2=%b hd2=%h exp 3 3 1 109",
                  Count, WriteSelect, Hit2, HitData2);
      end
      step();
      total++;
      if (WriteSelect !== 5'd4 || WriteData !== 32'h104) begin
         bad++;
         $display("FAIL full_drain4 got ws=%0d wd=%h exp 4 104",
                  WriteSelect, WriteData);
      end
      step();
      total++;
      if (WriteSelect !== 5'd9 || WriteData !== 32'h109 ||
          WriteEnable !== 1'b1) begin
         bad++;
         $display("FAIL full_drain5 got ws=%0d wd=%h we=%b exp 9 109 1",
                  WriteSelect, WriteData, WriteEnable);
      end
      step();
      total++;
      if (Count !== 3'd0) begin
         bad++;
         $display("FAIL full_empty got cnt=%0d exp 0", Count);
      end
   endtask

   task automatic test_waw();
      PortBusy = 1'b1;
      InValid  = 1'b1;
      InSelect = 5'd7;
      InData   = 32'h11;
      step();
      InData = 32'h22;
      step();
      InValid = 1'b0;
      LookupSelect1 = 5'd7;
      #1;
      total++;
      if (Hit1 !== 1'b1 || HitData1 !== 32'h22 || PendingMask !== 32'h80) begin
         bad++;
         $display("FAIL waw_lookup got hit=%b hd=%h pm=%h exp 1 22 80",
                  Hit1, HitData1, PendingMask);
      end
      PortBusy = 1'b0;
      #1;
      total++;
      if (WriteEnable !== 1'b1 || WriteData !== 32'h11) begin
         bad++;
         $display("FAIL waw_first got we=%b wd=%h exp 1 11", WriteEnable, WriteData);
      end
      step();
      total++;
      if (WriteData !== 32'h22 || HitData1 !== 32'h22 || Count !== 3'd1) begin
         bad++;
         $display("FAIL waw_second got wd=%h hd=%h cnt=%0d exp 22 22 1",
                  WriteData, HitData1, Count);
      end
      step();
      total++;
      if (Count !== 3'd0 || PendingMask !== 32'd0 || Hit1 !== 1'b0) begin
         bad++;
         $display("FAIL waw_done got cnt=%0d pm=%h hit=%b exp 0",
                  Count, PendingMask, Hit1);
      end
   endtask

   task automatic test_zero_sel();
      PortBusy      = 1'b0;
      InValid       = 1'b1;
      InSelect      = 5'd0;
      InData        = 32'hFFFFFFFF;
      LookupSelect1 = 5'd0;
      #1;
      total++;
      if (InReady !== 1'b1 || Hit1 !== 1'b0 || HitData1 !== 32'd0) begin
         bad++;
         $display("FAIL zero_offer got rdy=%b hit=%b hd=%h exp 1 0 0",
                  InReady, Hit1, HitData1);
      end
      step();
      InValid = 1'b0;
      #1;
      total++;
      if (Count !== 3'd0 || WriteEnable !== 1'b0 || PendingMask !== 32'd0) begin
         bad++;
         $display("FAIL zero_after got cnt=%0d we=%b pm=%h exp 0 0 0",
                  Count, WriteEnable, PendingMask);
      end
   endtask

   task automatic test_back_to_back();
      wb_entry_t q[$];
      wb_entry_t e;
      int        n;
      bit        acc;
      bit        pop;
      n = 0;
      for (int c = 0; c < 30; c++) begin
         PortBusy = (c < 5);
         InValid  = (c < 22);
         e.sel    = 5'(1 + (n % 31));
         e.data   = 32'hA000_0000 + 32'(n);
         InSelect = e.sel;
         InData   = e.data;
         LookupSelect2 = (q.size() != 0) ? q[$].sel : 5'd0;
         #1;
         total++;
         if (Count !== 3'(q.size()) || WriteEnable !== (q.size() != 0 && !PortBusy)) begin
            bad++;
            $display("FAIL b2b_state c=%0d got cnt=%0d we=%b exp cnt=%0d",
                     c, Count, WriteEnable, q.size());
         end
         if (q.size() != 0) begin
            total++;
            if (WriteSelect !== q[0].sel || WriteData !== q[0].data ||
                Hit2 !== 1'b1 || HitData2 !== q[$].data) begin
               bad++;
               $display("FAIL b2b_data c=%0d got ws=%0d wd=%h hd2=%h exp %0d %h %h",
                        c, WriteSelect, WriteData, HitData2,
                        q[0].sel, q[0].data, q[$].data);
            end
         end
         if (c >= 8 && c < 22) begin
            total++;
            if (Count !== 3'd3 && Count !== 3'd4) begin
               bad++;
               $display("FAIL b2b_steady c=%0d got cnt=%0d exp 3 or 4", c, Count);
            end
         end
         acc = InValid && (q.size() != 4);
         pop = (q.size() != 0) && !PortBusy;
         step();
         if (pop) void'(q.pop_front());
         if (acc) begin
            q.push_back(e);
            n++;
         end
      end
      InValid = 1'b0;
      total++;
      if (Count !== 3'd0 || q.size() != 0) begin
         bad++;
         $display("FAIL b2b_end got cnt=%0d exp 0 (model %0d)", Count, q.size());
      end
   endtask

   initial begin
      Reset         = 1'b0;
      InValid       = 1'b0;
      InSelect      = '0;
      InData        = '0;
      PortBusy      = 1'b0;
      LookupSelect1 = '0;
      LookupSelect2 = '0;
      #12 Reset = 1'b1;
      step();
      test_reset();
      test_single();
      test_full();
      test_waw();
      test_zero_sel();
      test_back_to_back();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/write_back_buffer.md
# write_back_buffer

Write-back buffer sitting between the MEM/WB result path and the register file write port (WriteData/WriteSelect/WriteEnable) of the decode stage. It accepts completed results through a valid/ready handshake and queues up to DEPTH of them. It drains one entry per cycle into the register file and serves read-after-write forwarding and hazard masks to the decode stage for results that are queued but not yet written.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- DATA_WIDTH, 32: result width.
- ADDR_WIDTH, 5: register select width; 2**ADDR_WIDTH registers, register 0 hardwired zero.

- Clk  in  1  rising-edge clock.
- Reset  in  1  asynchronous, active-low; low clears all state immediately.
- InValid  in  1  result offered.
- InReady  out  1  buffer can accept this cycle.
- InSelect  in  ADDR_WIDTH  destination register of offered result.
- InData  in  DATA_WIDTH  offered result value.
- PortBusy  in  1  register file write port unavailable; suppresses drain.
- WriteEnable  out  1  drive register file write enable.
- WriteSelect  out  ADDR_WIDTH  drive register file write select.
- WriteData  out  DATA_WIDTH  drive register file write data.
- LookupSelect1, LookupSelect2  in  ADDR_WIDTH  decode-stage read selects.
- Hit1, Hit2  out  1  lookup matches a queued entry.
- HitData1, HitData2  out  DATA_WIDTH  newest matching queued value.
- PendingMask  out  2**ADDR_WIDTH  bit r set if any queued entry targets r.
- Count  out  $clog2(DEPTH)+1  occupied entries.

## Operation
- Circular queue: head/tail pointers ADDR-independent, $clog2(DEPTH) bits, wrap modulo DEPTH; Count 0..DEPTH.
- Accept: InValid & InReady at rising edge. InReady = (Count != DEPTH); no same-cycle pass-through when full.
- InSelect == 0 on accept: handshake completes, nothing enqueued, Count unchanged.
- Drain: WriteEnable = (Count != 0) & !PortBusy; WriteSelect/WriteData = head entry. When WriteEnable is high, the head pops at the same edge at which the register file writes.
- Simultaneous accept and drain: both happen, Count unchanged, order preserved.
- Lookup (combinational): scan valid entries; Hit = any entry with matching select; HitData = youngest (closest to tail) match. The head entry being drained this cycle still counts. An offered-but-not-accepted input never hits. LookupSelect == 0 never hits, HitData = 0.
- PendingMask: OR of one-hot decoded selects of valid entries; bit 0 always 0.
- Write-after-write to the same register: both entries are kept and drained in order; lookup returns the younger.

## Timing
- Reset low: Count=0, pointers=0, InReady=1 after Reset, WriteEnable=0, WriteSelect=0, WriteData=0, Hit*=0, HitData*=0, PendingMask=0; takes effect asynchronously, with no dependence on Clk.
- Reset mid-operation: all queued entries are discarded; writes in flight are lost.
- Latency: accepted at edge k → WriteEnable high in cycle k..k+1 (if PortBusy low and entry at head) → written to register file at edge k+1.
- Lookup/PendingMask reflect accepted entries from the cycle after acceptance; they clear the cycle after the drain edge.
- Throughput: one accept and one drain per cycle.
- Drain outputs are combinational from registered head state; no combinational path from InValid/InData to any output except InReady-independent paths (none).

## Structure
- Package wb_pkg: default DATA_WIDTH/ADDR_WIDTH/DEPTH constants, wb_entry_t typedef {sel, data}.
- Sub-module wb_lookup: youngest-match search over the entry array given the head pointer and Count; instantiated twice (ports 1 and 2).
- Storage, pointers, Count and PendingMask live in write_back_buffer.

## Test plan
- Reset low with Count=3 mid-run → all outputs zero the same timestep, no Clk edge required; after release, InReady=1 and Count=0.
- Accept (5, 0xDEADBEEF), PortBusy=0 → next cycle WriteEnable=1, WriteSelect=5, WriteData=0xDEADBEEF, Hit1=1 for LookupSelect1=5; the cycle after that, Hit1=0 and PendingMask[5]=0.
- PortBusy=1, offer four results (1..4) → Count reaches 4, InReady=0, fifth held; release PortBusy → drains 1,2,3,4 in order, fifth accepted on first drain edge +1.
- Accept (7,0x11) then (7,0x22) with PortBusy=1 → HitData=0x22, PendingMask=0x80; drain writes 0x11 then 0x22.
- Offer InSelect=0 with InData=0xFFFFFFFF → InReady=1, Count stays 0, no WriteEnable, PendingMask[0]=0.
- Full queue with PortBusy=0 and InValid held → one accept and one drain per cycle, Count stays at DEPTH-1/DEPTH steady, with no loss or reordering across pointer wrap.
